// File: rtl/synch_fifo_flex_pkg.sv
// Shared constants and width helpers for the synch_fifo_flex family.
package synch_fifo_flex_pkg;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  // The count must hold 0..DEPTH inclusive, so it needs one more value than the pointers.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/synch_fifo_flex_if.sv
// Producer/consumer handshake bundle for synch_fifo_flex.
interface synch_fifo_flex_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 5
);
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  full_o;
  logic                  almost_full_o;
  logic                  overflow_o;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  empty_o;
  logic                  almost_empty_o;
  logic                  underflow_o;
  logic [CNT_WIDTH-1:0]  count_o;

  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  full_o, almost_full_o, overflow_o, rdata_o,
           empty_o, almost_empty_o, underflow_o, count_o
  );

  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output full_o, almost_full_o, overflow_o, rdata_o,
           empty_o, almost_empty_o, underflow_o, count_o
  );
endinterface

// File: rtl/synch_fifo_flex_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned AW         = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/synch_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, optional show-ahead read, occupancy count and level flags.
module synch_fifo_flex
  import synch_fifo_flex_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned FWFT       = FWFT_OFF,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input logic             clk_i,
  input logic             rst_n_i,
  synch_fifo_flex_if.slave bus
);

  localparam int unsigned CNT_WIDTH = cnt_width(DEPTH);
  localparam int unsigned AW        = ptr_width(DEPTH);

  if (DEPTH < 2 || !(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH) || FWFT > FWFT_ON) begin : g_bad_cfg
    $error("synch_fifo_flex: illegal DEPTH/AE_LEVEL/AF_LEVEL/FWFT combination");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q, count_nx;
  logic                  full_q, af_q, empty_q, ae_q, ovf_q, unf_q;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Explicit wrap at DEPTH-1 so non-power-of-2 depths never touch unused slots.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    rd_ok    = bus.rd_en_i & ~empty_q;
    wr_ok    = bus.wr_en_i & (~full_q | rd_ok);
    count_nx = count_q;
    if (wr_ok & ~rd_ok)      count_nx = count_q + CNT_WIDTH'(1);
    else if (rd_ok & ~wr_ok) count_nx = count_q - CNT_WIDTH'(1);
  end

  // Flags come from next-count so they line up with count_o on the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      af_q    <= (AF_LEVEL == 0);
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_nx;
      full_q  <= (count_nx == CNT_WIDTH'(DEPTH));
      af_q    <= (count_nx >= CNT_WIDTH'(AF_LEVEL));
      empty_q <= (count_nx == '0);
      ae_q    <= (count_nx <= CNT_WIDTH'(AE_LEVEL));
      ovf_q   <= bus.wr_en_i & ~wr_ok;
      unf_q   <= bus.rd_en_i & ~rd_ok;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr),
    .wdata_i (bus.wdata_i),
    .raddr_i (rd_ptr),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign bus.rdata_o = mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)   rdata_q <= '0;
      else if (rd_ok) rdata_q <= mem_rdata;
    end
    assign bus.rdata_o = rdata_q;
  end

  assign bus.full_o         = full_q;
  assign bus.almost_full_o  = af_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.underflow_o    = unf_q;
  assign bus.count_o        = count_q;

endmodule
